// File: rtl/hr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hr_pkg
//  Purpose  : Shared types and constants for the PmodAD1 heart-rate sampler.
//             Holds the sampler FSM state encoding, the ADC frame length and
//             the converted sample width.
//  Revision : 1.0 - initial release
// ============================================================================
package hr_pkg;

    // Sampler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2,
        LOAD  = 2'd3
    } hr_state_t;

    // SCLK cycles per AD7476 frame (4 leading zeros + 12 data bits)
    localparam int C_FRAME_BITS = 16;
    // Width of one converted sample
    localparam int C_SAMPLE_W   = 12;

    // Strip the leading-zero nibble from a received frame.
    function automatic logic [C_SAMPLE_W-1:0] frame_sample(
        input logic [C_FRAME_BITS-1:0] frame
    );
        return frame[C_SAMPLE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hr_adc_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hr_adc_spi_rx
//  Purpose  : SCLK generator and dual-channel shift engine for one PmodAD1
//             frame. A start pulse launches 16 SCLK periods (idle high, first
//             transition falling); done pulses on the 16th rising edge.
//  Ports    : sysCLK, resetN      - clock, asynchronous active-low reset
//             start               - begin a frame (one-cycle pulse)
//             done                - combinational pulse on the last SCLK rise
//             sclk                - serial clock to the ADC
//             d0, d1              - raw serial data from the ADC
//             shift0, shift1      - received frames, MSB first
//  Revision : 1.0 - initial release
// ============================================================================
module hr_adc_spi_rx
    import hr_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                    sysCLK,
    input  logic                    resetN,
    input  logic                    start,
    output logic                    done,
    output logic                    sclk,
    input  logic                    d0,
    input  logic                    d1,
    output logic [C_FRAME_BITS-1:0] shift0,
    output logic [C_FRAME_BITS-1:0] shift1
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_CNT_W = $clog2(C_FRAME_BITS);

    logic                    r_busy;
    logic [C_DIV_W-1:0]      r_div_cnt;
    logic [C_CNT_W-1:0]      r_rise_cnt;
    logic                    r_sclk;
    logic [1:0]              r_d0_sync;
    logic [1:0]              r_d1_sync;
    logic [1:0]              r_rise_pipe;
    logic [C_FRAME_BITS-1:0] r_shift0;
    logic [C_FRAME_BITS-1:0] r_shift1;

    logic w_tick;
    logic w_rise;
    logic w_last;

    assign w_tick = r_busy && (r_div_cnt == C_DIV_W'(CLK_DIV - 1));
    assign w_rise = w_tick && !r_sclk;
    assign w_last = w_rise && (r_rise_cnt == C_CNT_W'(C_FRAME_BITS - 1));

    assign done   = w_last;
    assign sclk   = r_sclk;
    assign shift0 = r_shift0;
    assign shift1 = r_shift1;

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_busy      <= 1'b0;
            r_div_cnt   <= '0;
            r_rise_cnt  <= '0;
            r_sclk      <= 1'b1;
            r_d0_sync   <= '0;
            r_d1_sync   <= '0;
            r_rise_pipe <= '0;
            r_shift0    <= '0;
            r_shift1    <= '0;
        end else begin
            r_d0_sync   <= {r_d0_sync[0], d0};
            r_d1_sync   <= {r_d1_sync[0], d1};
            // The synchronizer delays data by two cycles, so the rising-edge
            // strobe is delayed by the same amount; the bit shifted in is the
            // pin value just before SCLK rose.
            r_rise_pipe <= {r_rise_pipe[0], w_rise};
            if (r_rise_pipe[1]) begin
                r_shift0 <= {r_shift0[C_FRAME_BITS-2:0], r_d0_sync[1]};
                r_shift1 <= {r_shift1[C_FRAME_BITS-2:0], r_d1_sync[1]};
            end

            if (start) begin
                r_busy     <= 1'b1;
                r_div_cnt  <= '0;
                r_rise_cnt <= '0;
                r_sclk     <= 1'b1;
            end else if (r_busy) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sclk    <= ~r_sclk;
                    if (w_last) begin
                        r_busy <= 1'b0;
                    end else if (w_rise) begin
                        r_rise_cnt <= r_rise_cnt + 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hr_adc_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hr_adc_sampler
//  Purpose  : Periodic dual-channel PmodAD1 sampler. Starts a conversion every
//             SAMPLE_PERIOD cycles, enforces a CS-high quiet time, latches the
//             12-bit results and offers them through a rdy/ack handshake with
//             a sticky overrun flag.
//  Options  : HR_ADC_AVG_EN - when defined, sample0/1 carry the 4-point moving
//             average of the last four conversions instead of raw results.
//  Ports    : sysCLK, resetN        - clock, asynchronous active-low reset
//             adc_cs_n, adc_sclk    - ADC chip select and serial clock
//             adc_d0, adc_d1        - ADC serial data, channel 0 / 1
//             sample0, sample1      - latched results
//             sample_rdy/sample_ack - new-pair flag and consumer acknowledge
//             overrun               - sticky: unacknowledged pair overwritten
//  Revision : 1.0 - initial release
// ============================================================================
module hr_adc_sampler
    import hr_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 8400,
    // Must be at least 2 so the delayed final bit lands before LOAD.
    parameter int QUIET_CYC     = 4
) (
    input  logic                  sysCLK,
    input  logic                  resetN,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_d0,
    input  logic                  adc_d1,
    output logic [C_SAMPLE_W-1:0] sample0,
    output logic [C_SAMPLE_W-1:0] sample1,
    output logic                  sample_rdy,
    input  logic                  sample_ack,
    output logic                  overrun
);

    localparam int C_PER_W   = $clog2(SAMPLE_PERIOD);
    localparam int C_QUIET_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    hr_state_t               r_state;
    logic [C_PER_W-1:0]      r_period_cnt;
    logic [C_QUIET_W-1:0]    r_quiet_cnt;
    logic                    r_cs_n;
    logic [C_SAMPLE_W-1:0]   r_sample0;
    logic [C_SAMPLE_W-1:0]   r_sample1;
    logic                    r_rdy;
    logic                    r_overrun;

    logic                    w_wrap;
    logic                    w_start;
    logic                    w_spi_done;
    logic [C_FRAME_BITS-1:0] w_shift0;
    logic [C_FRAME_BITS-1:0] w_shift1;
    logic [C_SAMPLE_W-1:0]   w_raw0;
    logic [C_SAMPLE_W-1:0]   w_raw1;
    logic [C_SAMPLE_W-1:0]   w_new0;
    logic [C_SAMPLE_W-1:0]   w_new1;

    assign w_wrap  = (r_period_cnt == C_PER_W'(SAMPLE_PERIOD - 1));
    // A wrap seen outside IDLE is simply dropped, never queued.
    assign w_start = (r_state == IDLE) && w_wrap;
    assign w_raw0  = frame_sample(w_shift0);
    assign w_raw1  = frame_sample(w_shift1);

    hr_adc_spi_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_rx (
        .sysCLK (sysCLK),
        .resetN (resetN),
        .start  (w_start),
        .done   (w_spi_done),
        .sclk   (adc_sclk),
        .d0     (adc_d0),
        .d1     (adc_d1),
        .shift0 (w_shift0),
        .shift1 (w_shift1)
    );

`ifdef HR_ADC_AVG_EN
    localparam int C_SUM_W = C_SAMPLE_W + 2;

    logic [2:0][C_SAMPLE_W-1:0] r_hist0;
    logic [2:0][C_SAMPLE_W-1:0] r_hist1;
    logic [C_SUM_W-1:0]         w_sum0;
    logic [C_SUM_W-1:0]         w_sum1;

    assign w_sum0 = C_SUM_W'(w_raw0) + C_SUM_W'(r_hist0[0])
                  + C_SUM_W'(r_hist0[1]) + C_SUM_W'(r_hist0[2]);
    assign w_sum1 = C_SUM_W'(w_raw1) + C_SUM_W'(r_hist1[0])
                  + C_SUM_W'(r_hist1[1]) + C_SUM_W'(r_hist1[2]);
    assign w_new0 = w_sum0[C_SUM_W-1:2];
    assign w_new1 = w_sum1[C_SUM_W-1:2];

    // History of the three previous raw conversions, newest in slot 0.
    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
        end else if (r_state == LOAD) begin
            r_hist0 <= {r_hist0[1:0], w_raw0};
            r_hist1 <= {r_hist1[1:0], w_raw1};
        end
    end
`else
    assign w_new0 = w_raw0;
    assign w_new1 = w_raw1;
`endif

    // Free-running conversion period counter, active in every state.
    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_period_cnt <= '0;
        end else if (w_wrap) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_cs_n      <= 1'b1;
            r_quiet_cnt <= '0;
            r_sample0   <= '0;
            r_sample1   <= '0;
            r_rdy       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wrap) begin
                        r_state <= CONV;
                        r_cs_n  <= 1'b0;
                    end
                end
                CONV: begin
                    if (w_spi_done) begin
                        r_state     <= QUIET;
                        r_cs_n      <= 1'b1;
                        r_quiet_cnt <= '0;
                    end
                end
                QUIET: begin
                    if (r_quiet_cnt == C_QUIET_W'(QUIET_CYC - 1)) begin
                        r_state <= LOAD;
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A load takes priority over an acknowledge in the same cycle:
            // the new pair stays pending and overrun is left as it was.
            if (r_state == LOAD) begin
                r_sample0 <= w_new0;
                r_sample1 <= w_new1;
                r_rdy     <= 1'b1;
                if (r_rdy && !sample_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rdy && sample_ack) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign adc_cs_n   = r_cs_n;
    assign sample0    = r_sample0;
    assign sample1    = r_sample1;
    assign sample_rdy = r_rdy;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hr_adc_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hr_adc_sampler
//  Purpose  : Directed self-checking bench for hr_adc_sampler with a PmodAD1
//             behavioural model and an expected-result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hr_adc_sampler;
    import hr_pkg::*;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 200;
    localparam int QUIET_CYC     = 4;
    localparam int LATENCY       = 32 * CLK_DIV + QUIET_CYC + 1;

    typedef struct packed {
        logic [11:0] s0;
        logic [11:0] s1;
    } pair_t;

    logic        sysCLK = 1'b0;
    logic        resetN;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_d0;
    logic        adc_d1;
    logic [11:0] sample0;
    logic [11:0] sample1;
    logic        sample_rdy;
    logic        sample_ack;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    pair_t       sb_q[$];
    logic [11:0] m_hist0[3];
    logic [11:0] m_hist1[3];

    logic [15:0] adc_frame0 = 16'h0000;
    logic [15:0] adc_frame1 = 16'h0000;
    int          fall_cnt   = 0;

    always #5 sysCLK = ~sysCLK;

    hr_adc_sampler #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .QUIET_CYC     (QUIET_CYC)
    ) dut (
        .sysCLK     (sysCLK),
        .resetN     (resetN),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_d0     (adc_d0),
        .adc_d1     (adc_d1),
        .sample0    (sample0),
        .sample1    (sample1),
        .sample_rdy (sample_rdy),
        .sample_ack (sample_ack),
        .overrun    (overrun)
    );

    // PmodAD1 model: a new bit, MSB first, after each SCLK falling edge.
    initial begin
        adc_d0 = 1'b0;
        adc_d1 = 1'b0;
        forever begin
            @(negedge adc_sclk or negedge adc_cs_n);
            if (!adc_cs_n && adc_sclk) begin
                fall_cnt = 0;
            end else if (!adc_cs_n && !adc_sclk) begin
                if (fall_cnt < 16) begin
                    adc_d0 = adc_frame0[15 - fall_cnt];
                    adc_d1 = adc_frame1[15 - fall_cnt];
                end
                fall_cnt++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist0[i] = '0;
            m_hist1[i] = '0;
        end
    endtask

    task automatic sb_push(input logic [11:0] r0, input logic [11:0] r1);
        pair_t p;
`ifdef HR_ADC_AVG_EN
        logic [13:0] s0;
        logic [13:0] s1;
        s0 = 14'(r0) + 14'(m_hist0[0]) + 14'(m_hist0[1]) + 14'(m_hist0[2]);
        s1 = 14'(r1) + 14'(m_hist1[0]) + 14'(m_hist1[1]) + 14'(m_hist1[2]);
        p.s0 = s0[13:2];
        p.s1 = s1[13:2];
        m_hist0[2] = m_hist0[1]; m_hist0[1] = m_hist0[0]; m_hist0[0] = r0;
        m_hist1[2] = m_hist1[1]; m_hist1[1] = m_hist1[0]; m_hist1[0] = r1;
`else
        p.s0 = r0;
        p.s1 = r1;
`endif
        sb_q.push_back(p);
    endtask

    // Bounded wait for CS to fall; returns the number of cycles waited.
    task automatic wait_cs_fall(input string tag, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < SAMPLE_PERIOD + 8) begin
            tick();
            waited++;
            if (!adc_cs_n) seen = 1'b1;
        end
        check({tag, "_cs_fall"}, 32'(seen), 32'd1);
    endtask

    // One full conversion; the result is checked in the cycle sample_rdy
    // is due to rise.
    task automatic run_conv(input string tag, input logic [15:0] f0, input logic [15:0] f1,
                            input bit ack_at_load, input logic exp_ovr, output int waited);
        bit    seen;
        logic  prev_rdy;
        pair_t exp_p;
        adc_frame0 = f0;
        adc_frame1 = f1;
        sb_push(f0[11:0], f1[11:0]);
        wait_cs_fall(tag, waited, seen);
        if (!seen) begin
            void'(sb_q.pop_back());
            return;
        end
        prev_rdy = sample_rdy;
        repeat (LATENCY - 1) tick();
        if (ack_at_load) sample_ack = 1'b1;
        if (!prev_rdy) check({tag, "_rdy_early"}, 32'(sample_rdy), 32'd0);
        tick();
        sample_ack = 1'b0;
        exp_p = sb_q.pop_front();
        check({tag, "_rdy"},     32'(sample_rdy), 32'd1);
        check({tag, "_cs_high"}, 32'(adc_cs_n),   32'd1);
        check({tag, "_falls"},   32'(fall_cnt),   32'd16);
        check({tag, "_s0"},      32'(sample0),    32'(exp_p.s0));
        check({tag, "_s1"},      32'(sample1),    32'(exp_p.s1));
        check({tag, "_ovr"},     32'(overrun),    32'(exp_ovr));
    endtask

    task automatic do_ack(input string tag);
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
        check({tag, "_rdy_clr"}, 32'(sample_rdy), 32'd0);
        check({tag, "_ovr_clr"}, 32'(overrun),    32'd0);
    endtask

    initial begin
        int  waited;
        bit  seen;
        resetN     = 1'b0;
        sample_ack = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_cs_n",  32'(adc_cs_n),   32'd1);
        check("rst_sclk",  32'(adc_sclk),   32'd1);
        check("rst_s0",    32'(sample0),    32'd0);
        check("rst_s1",    32'(sample1),    32'd0);
        check("rst_rdy",   32'(sample_rdy), 32'd0);
        check("rst_ovr",   32'(overrun),    32'd0);
        resetN = 1'b1;

        // Basic conversion, start delay and latency
        run_conv("basic", 16'h0ABC, 16'h0123, 1'b0, 1'b0, waited);
        check("first_conv_delay", 32'(waited), 32'(SAMPLE_PERIOD));
        do_ack("basic_ack");

        // Ack with nothing pending is ignored
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
        tick();
        check("idle_ack_rdy", 32'(sample_rdy), 32'd0);

        // Overrun: two conversions without ack
        run_conv("ovr_a", 16'h0100, 16'h0F0F, 1'b0, 1'b0, waited);
        run_conv("ovr_b", 16'h0200, 16'h0A5A, 1'b0, 1'b1, waited);
        do_ack("ovr_ack");

        // Leading nibble discarded; ack coinciding with LOAD
        run_conv("nib",    16'hF300, 16'h5456, 1'b0, 1'b0, waited);
        run_conv("coin_a", 16'h0FFF, 16'h0000, 1'b1, 1'b0, waited);
        run_conv("coin_b", 16'h0123, 16'h0321, 1'b0, 1'b1, waited);
        run_conv("coin_c", 16'h0555, 16'h0AAA, 1'b1, 1'b1, waited);

        // Reset during bit 8 of a conversion (rdy and overrun both set)
        adc_frame0 = 16'h0777;
        adc_frame1 = 16'h0888;
        wait_cs_fall("abort", waited, seen);
        repeat (15 * CLK_DIV + 2) tick();
        check("abort_pre_sclk", 32'(adc_sclk), 32'd0);
        resetN = 1'b0;
        #1;
        check("abort_cs_n", 32'(adc_cs_n),   32'd1);
        check("abort_sclk", 32'(adc_sclk),   32'd1);
        check("abort_rdy",  32'(sample_rdy), 32'd0);
        check("abort_ovr",  32'(overrun),    32'd0);
        check("abort_s0",   32'(sample0),    32'd0);
        model_reset();
        tick();
        tick();
        resetN = 1'b1;

        // Averaging sequence (raw pass-through when averaging is off)
        run_conv("avg0", 16'h0400, 16'h0004, 1'b0, 1'b0, waited);
        check("rst_restart_delay", 32'(waited), 32'(SAMPLE_PERIOD));
        do_ack("avg0_ack");
        run_conv("avg1", 16'h0800, 16'h0008, 1'b0, 1'b0, waited);
        do_ack("avg1_ack");
        run_conv("avg2", 16'h0C00, 16'h000C, 1'b0, 1'b0, waited);
        do_ack("avg2_ack");
        run_conv("avg3", 16'h0000, 16'h0FFC, 1'b0, 1'b0, waited);
        do_ack("avg3_ack");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hr_adc_sampler.md
HR_ADC_SAMPLER -- requirements
Module: hr_adc_sampler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: sysCLK cycles per SCLK half-period (min 2).
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 8400: sysCLK cycles between conversion starts (1 kHz at 8.4 MHz); minimum 32*CLK_DIV + QUIET_CYC + 4.
REQ-003 The block SHALL have parameter QUIET_CYC, default 4: minimum sysCLK cycles CS stays high after a conversion.
REQ-004 The block SHALL have port sysCLK, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port adc_cs_n, output, 1 bit: PmodAD1 chip select.
REQ-007 The block SHALL have port adc_sclk, output, 1 bit: PmodAD1 serial clock.
REQ-008 The block SHALL have port adc_d0, input, 1 bit: channel-0 serial data (pulse sensor).
REQ-009 The block SHALL have port adc_d1, input, 1 bit: channel-1 serial data.
REQ-010 The block SHALL have port sample0, output, 12 bits: latched channel-0 result.
REQ-011 The block SHALL have port sample1, output, 12 bits: latched channel-1 result.
REQ-012 The block SHALL have port sample_rdy, output, 1 bit: new sample pair available.
REQ-013 The block SHALL have port sample_ack, input, 1 bit: consumer has taken the pair.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, a pair was overwritten before being acknowledged.

Function
REQ-015 The FSM SHALL use states IDLE, CONV, QUIET and LOAD.
REQ-016 In IDLE, a free-running period counter wrapping at SAMPLE_PERIOD-1 SHALL cause IDLE->CONV on wrap.
REQ-017 In CONV, adc_cs_n SHALL be 0 and adc_sclk SHALL toggle every CLK_DIV cycles, starting high, for exactly 16 falling edges.
REQ-018 The block SHALL sample adc_d0 and adc_d1 into 16-bit shift registers on each adc_sclk rising edge, MSB first; the first sample SHALL be taken after the first falling edge.
REQ-019 After 16 bits, CONV->QUIET: adc_cs_n SHALL be 1, adc_sclk SHALL be 1, and the FSM SHALL hold for QUIET_CYC cycles.
REQ-020 QUIET->LOAD SHALL take one cycle: sample0/1 SHALL be loaded from shift[11:0] (the 4 leading zeros are discarded), sample_rdy SHALL be set, and the FSM SHALL return to IDLE.
REQ-021 Latency from the adc_cs_n falling edge to sample_rdy rising SHALL be 32*CLK_DIV + QUIET_CYC + 1 cycles.
REQ-022 sample_rdy SHALL remain 1 until sample_ack is seen high on a rising edge while sample_rdy=1; it SHALL clear on the following cycle.
REQ-023 sample_ack while sample_rdy=0 SHALL be ignored.
REQ-024 If LOAD occurs while sample_rdy=1 and sample_ack is not simultaneously high: the outputs SHALL be overwritten, sample_rdy SHALL stay 1, and overrun SHALL be set.
REQ-025 If LOAD and sample_ack coincide: the new data SHALL load, sample_rdy SHALL stay 1, and overrun SHALL be unchanged.
REQ-026 overrun SHALL clear only on an accepted sample_ack that does not coincide with LOAD, or on reset.
REQ-027 The period counter SHALL run in all states; a wrap outside IDLE SHALL be ignored and SHALL not be queued.
REQ-028 adc_d0 and adc_d1 SHALL pass through a 2-flop synchronizer; the RTL sample point SHALL compensate by taking bits 2 cycles after the adc_sclk rising edge.

Reset
REQ-029 Reset SHALL be asynchronous; on assertion: FSM=IDLE, adc_cs_n=1, adc_sclk=1, sample0=0, sample1=0, sample_rdy=0, overrun=0, all counters=0.
REQ-030 Reset asserted mid-CONV SHALL abort immediately with no partial result loaded.
REQ-031 The first conversion SHALL start SAMPLE_PERIOD cycles after reset deassertion.

Configuration
REQ-032 With HR_ADC_AVG_EN defined, sample0/1 SHALL be the 4-point moving average of the last four conversions per channel: 14-bit sum >> 2, truncated, history cleared to 0 on reset.
REQ-033 Without HR_ADC_AVG_EN, sample0/1 SHALL be the raw conversion results with no averaging logic.

Structure
REQ-034 FSM state enum, the 16-bit frame length constant and the 12-bit sample width SHALL live in package hr_pkg.
REQ-035 The SCLK/shift engine SHALL be sub-module hr_adc_spi_rx (start/done handshake, two 16-bit shift outputs); the FSM, handshake and averaging stay in the top.

Verification
REQ-036 An ADC model driving d0=0x0ABC and d1=0x0123 with CLK_DIV=4 and QUIET_CYC=4 SHALL yield sample0=0xABC, sample1=0x123, sample_rdy high 133 cycles after adc_cs_n falls, and exactly 16 SCLK falling edges.
REQ-037 With sample_ack held low across two conversions (0x100 then 0x200): sample0=0x200, sample_rdy=1, overrun=1; one ack SHALL then clear both flags the next cycle.
REQ-038 sample_ack asserted in the same cycle as LOAD SHALL leave sample_rdy=1 with the new data and overrun=0.
REQ-039 resetN pulsed low during bit 8 of CONV SHALL give adc_cs_n=1 and sample_rdy=0 immediately, with the next conversion starting SAMPLE_PERIOD cycles after release.
REQ-040 With HR_ADC_AVG_EN defined, conversions 0x400, 0x800, 0xC00, 0x000 SHALL give outputs 0x100, 0x300, 0x600, 0x600.
